// File: rtl/mem_access_arbiter_if.sv
`timescale 1ns/1ps
// mem_access_arbiter_if: request/response handshakes for IFU and LSU plus the
// shared data-memory port. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives requests and returns memory data.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int WDT_W  = 4
);
    // IFU channel (read-only fetch)
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_rdata;

    // LSU channel (load/store)
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [WDT_W-1:0]  lsu_wdt_op;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_rdata;

    // Shared memory port
    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [WDT_W-1:0]  mem_wdt_op;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wdt_op, lsu_resp_ready,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_ren, mem_wen, mem_addr, mem_wdata, mem_wdt_op
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wdt_op, lsu_resp_ready,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_wdt_op
    );
endinterface

// File: rtl/mem_access_arbiter.sv
`timescale 1ns/1ps
// mem_access_arbiter: shares the single data-memory port between the IFU
// (fetch, always 64-bit reads) and the LSU (loads and stores). One access is
// outstanding at a time and runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// The LSU has priority, but a saturating starvation counter forces an IFU
// grant after STARVE_MAX consecutive LSU grants while the IFU was waiting.
module mem_access_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int WDT_W      = 4,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_arbiter_if.slave  bus
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Owner of the access in flight
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Fetches are always full-width
    localparam logic [WDT_W-1:0] WDT64 = WDT_W'(4'b1000);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    logic [1:0]        state_r;
    logic              run_en_r;        // low while in reset and for the first edge after release
    logic              owner_r;
    logic              wen_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic [STV_W-1:0]  starve_cnt_r;

    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [WDT_W-1:0]  wdt_op_r;
    logic [DATA_W-1:0] rdata_r;
    logic              mem_ren_r;
    logic              mem_wen_r;
    logic              ifu_resp_valid_r;
    logic              lsu_resp_valid_r;

    logic              ifu_grant_s;
    logic              lsu_grant_s;
    logic              resp_taken_s;

    // Arbitration: grant only in IDLE; LSU wins unless the IFU has been starved
    always_comb begin
        ifu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
        if (run_en_r && (state_r == ST_IDLE)) begin
            if (bus.lsu_req_valid && bus.ifu_req_valid) begin
                if (starve_cnt_r == STV_MAX) begin
                    ifu_grant_s = 1'b1;
                end else begin
                    lsu_grant_s = 1'b1;
                end
            end else if (bus.lsu_req_valid) begin
                lsu_grant_s = 1'b1;
            end else if (bus.ifu_req_valid) begin
                ifu_grant_s = 1'b1;
            end else begin
                ifu_grant_s = 1'b0;
                lsu_grant_s = 1'b0;
            end
        end else begin
            ifu_grant_s = 1'b0;
            lsu_grant_s = 1'b0;
        end
    end

    // Response handshake from whichever requester owns the access
    always_comb begin
        resp_taken_s = 1'b0;
        if (owner_r == OWN_LSU) begin
            resp_taken_s = lsu_resp_valid_r && bus.lsu_resp_ready;
        end else begin
            resp_taken_s = ifu_resp_valid_r && bus.ifu_resp_ready;
        end
    end

    // Grant enable: keeps ready low while reset is applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en_r <= 1'b0;
        end else begin
            run_en_r <= 1'b1;
        end
    end

    // Starvation counter: counts LSU grants taken while the IFU was waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {STV_W{1'b0}};
        end else if (ifu_grant_s || !bus.ifu_req_valid) begin
            starve_cnt_r <= {STV_W{1'b0}};
        end else if (lsu_grant_s && (starve_cnt_r != STV_MAX)) begin
            starve_cnt_r <= starve_cnt_r + STV_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Access sequencer: latch request, strobe memory, wait, hold response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            owner_r          <= OWN_IFU;
            wen_r            <= 1'b0;
            wait_cnt_r       <= {CNT_W{1'b0}};
            addr_r           <= {ADDR_W{1'b0}};
            wdata_r          <= {DATA_W{1'b0}};
            wdt_op_r         <= {WDT_W{1'b0}};
            rdata_r          <= {DATA_W{1'b0}};
            mem_ren_r        <= 1'b0;
            mem_wen_r        <= 1'b0;
            ifu_resp_valid_r <= 1'b0;
            lsu_resp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (lsu_grant_s) begin
                        owner_r   <= OWN_LSU;
                        wen_r     <= bus.lsu_wen;
                        addr_r    <= bus.lsu_addr;
                        wdata_r   <= bus.lsu_wdata;
                        wdt_op_r  <= bus.lsu_wdt_op;
                        mem_ren_r <= !bus.lsu_wen;
                        mem_wen_r <= bus.lsu_wen;
                        state_r   <= ST_ISSUE;
                    end else if (ifu_grant_s) begin
                        owner_r   <= OWN_IFU;
                        wen_r     <= 1'b0;
                        addr_r    <= bus.ifu_addr;
                        wdata_r   <= {DATA_W{1'b0}};
                        wdt_op_r  <= WDT64;
                        mem_ren_r <= 1'b1;
                        mem_wen_r <= 1'b0;
                        state_r   <= ST_ISSUE;
                    end else begin
                        mem_ren_r <= 1'b0;
                        mem_wen_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Strobe was visible for exactly this cycle
                    mem_ren_r  <= 1'b0;
                    mem_wen_r  <= 1'b0;
                    wait_cnt_r <= LAT_LOAD;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt_r == CNT_W'(1)) begin
                        // Stores complete with zero data
                        rdata_r          <= wen_r ? {DATA_W{1'b0}} : bus.mem_rdata;
                        ifu_resp_valid_r <= (owner_r == OWN_IFU);
                        lsu_resp_valid_r <= (owner_r == OWN_LSU);
                        wait_cnt_r       <= {CNT_W{1'b0}};
                        state_r          <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - CNT_W'(1);
                        state_r    <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (resp_taken_s) begin
                        ifu_resp_valid_r <= 1'b0;
                        lsu_resp_valid_r <= 1'b0;
                        state_r          <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    // Unreachable encoding: drop everything and return to IDLE
                    mem_ren_r        <= 1'b0;
                    mem_wen_r        <= 1'b0;
                    ifu_resp_valid_r <= 1'b0;
                    lsu_resp_valid_r <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake readiness follows the combinational grant
    assign bus.ifu_req_ready  = ifu_grant_s;
    assign bus.lsu_req_ready  = lsu_grant_s;

    // Registered response and memory-port outputs
    assign bus.ifu_resp_valid = ifu_resp_valid_r;
    assign bus.lsu_resp_valid = lsu_resp_valid_r;
    assign bus.ifu_rdata      = rdata_r;
    assign bus.lsu_rdata      = rdata_r;
    assign bus.mem_ren        = mem_ren_r;
    assign bus.mem_wen        = mem_wen_r;
    assign bus.mem_addr       = addr_r;
    assign bus.mem_wdata      = wdata_r;
    assign bus.mem_wdt_op     = wdt_op_r;

endmodule

// File: tb/tb_mem_access_arbiter.sv
`timescale 1ns/1ps
// tb_mem_access_arbiter: directed bench for the memory access arbiter.
// dut1 runs with a one-cycle memory, dut3 with a three-cycle memory.
module tb_mem_access_arbiter;

    localparam logic [3:0] WDT32 = 4'b0100;
    localparam logic [3:0] WDT64 = 4'b1000;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Expected response: owner 1 = LSU, 0 = IFU
    typedef struct packed {
        logic        owner;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    mem_access_arbiter_if bus1 ();
    mem_access_arbiter_if bus3 ();

    mem_access_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mem_access_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_A5A5, a[31:0]};
    endfunction

    // Pop the scoreboard when dut1 presents a response
    task automatic check_resp1();
        exp_t e;
        if (bus1.ifu_resp_valid || bus1.lsu_resp_valid) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_resp: observed response expected none");
            end
            chk("resp_exclusive", 64'(bus1.ifu_resp_valid & bus1.lsu_resp_valid), 64'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_owner", 64'(bus1.lsu_resp_valid), 64'(e.owner));
                chk("resp_data", bus1.lsu_resp_valid ? bus1.lsu_rdata : bus1.ifu_rdata, e.data);
            end
        end
    endtask

    // All dut1 outputs must be zero
    task automatic chk_quiet(input string pfx);
        chk({pfx, "_ifu_req_ready"},  64'(bus1.ifu_req_ready), 64'd0);
        chk({pfx, "_lsu_req_ready"},  64'(bus1.lsu_req_ready), 64'd0);
        chk({pfx, "_ifu_resp_valid"}, 64'(bus1.ifu_resp_valid), 64'd0);
        chk({pfx, "_lsu_resp_valid"}, 64'(bus1.lsu_resp_valid), 64'd0);
        chk({pfx, "_mem_ren"},        64'(bus1.mem_ren), 64'd0);
        chk({pfx, "_mem_wen"},        64'(bus1.mem_wen), 64'd0);
        chk({pfx, "_mem_addr"},       bus1.mem_addr, 64'd0);
        chk({pfx, "_mem_wdata"},      bus1.mem_wdata, 64'd0);
        chk({pfx, "_mem_wdt_op"},     64'(bus1.mem_wdt_op), 64'd0);
        chk({pfx, "_rdata"},          bus1.lsu_rdata | bus1.ifu_rdata, 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        int          grants;
        int          cyc;
        logic        exp_lsu;

        rst_n = 1'b0;
        bus1.ifu_req_valid = 1'b1; bus1.ifu_addr = 64'd0; bus1.ifu_resp_ready = 1'b1;
        bus1.lsu_req_valid = 1'b1; bus1.lsu_addr = 64'd0; bus1.lsu_wen = 1'b0;
        bus1.lsu_wdata = 64'd0; bus1.lsu_wdt_op = WDT64; bus1.lsu_resp_ready = 1'b1;
        bus1.mem_rdata = 64'd0;
        bus3.ifu_req_valid = 1'b0; bus3.ifu_addr = 64'd0; bus3.ifu_resp_ready = 1'b1;
        bus3.lsu_req_valid = 1'b0; bus3.lsu_addr = 64'd0; bus3.lsu_wen = 1'b0;
        bus3.lsu_wdata = 64'd0; bus3.lsu_wdt_op = WDT64; bus3.lsu_resp_ready = 1'b1;
        bus3.mem_rdata = 64'd0;

        // ---- Reset state (requests asserted, must not be granted) ----
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("rst");
        @(negedge clk);
        bus1.ifu_req_valid = 1'b0;
        bus1.lsu_req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // ---- IFU read, MEM_LAT=1 ----
        d = 64'h0000_0013_0000_0093;
        @(negedge clk);
        bus1.ifu_req_valid = 1'b1; bus1.ifu_addr = 64'h0000_0000_8000_0000;
        #1;
        chk("ifu_rd_ready", 64'(bus1.ifu_req_ready), 64'd1);
        chk("ifu_rd_lsu_ready", 64'(bus1.lsu_req_ready), 64'd0);
        sb.push_back('{owner: 1'b0, data: d});
        @(negedge clk);                              // T+1
        bus1.mem_rdata = d;
        #1;
        chk("ifu_rd_ren", 64'(bus1.mem_ren), 64'd1);
        chk("ifu_rd_wen", 64'(bus1.mem_wen), 64'd0);
        chk("ifu_rd_addr", bus1.mem_addr, 64'h0000_0000_8000_0000);
        chk("ifu_rd_wdt", 64'(bus1.mem_wdt_op), 64'(WDT64));
        chk("ifu_rd_issue_ready", 64'(bus1.ifu_req_ready), 64'd0);
        @(negedge clk);                              // T+2
        bus1.ifu_req_valid = 1'b0;
        #1;
        chk("ifu_rd_ren_once", 64'(bus1.mem_ren), 64'd0);
        chk("ifu_rd_early_valid", 64'(bus1.ifu_resp_valid), 64'd0);
        @(negedge clk);                              // T+3
        #1;
        chk("ifu_rd_valid", 64'(bus1.ifu_resp_valid), 64'd1);
        check_resp1();
        @(negedge clk);
        #1;
        chk("ifu_rd_done", 64'(bus1.ifu_resp_valid), 64'd0);

        // ---- LSU 32-bit store ----
        @(negedge clk);
        bus1.lsu_req_valid = 1'b1; bus1.lsu_wen = 1'b1;
        bus1.lsu_addr = 64'h0000_0000_8000_1004;
        bus1.lsu_wdata = 64'h0000_0000_DEAD_BEEF; bus1.lsu_wdt_op = WDT32;
        bus1.mem_rdata = 64'h1234_5678_9ABC_DEF0;    // must not leak into store response
        #1;
        chk("st_ready", 64'(bus1.lsu_req_ready), 64'd1);
        sb.push_back('{owner: 1'b1, data: 64'd0});
        @(negedge clk);                              // T+1
        bus1.lsu_req_valid = 1'b0;
        #1;
        chk("st_wen", 64'(bus1.mem_wen), 64'd1);
        chk("st_ren", 64'(bus1.mem_ren), 64'd0);
        chk("st_addr", bus1.mem_addr, 64'h0000_0000_8000_1004);
        chk("st_wdata", bus1.mem_wdata, 64'h0000_0000_DEAD_BEEF);
        chk("st_wdt", 64'(bus1.mem_wdt_op), 64'(WDT32));
        @(negedge clk);                              // T+2
        #1;
        chk("st_wen_once", 64'(bus1.mem_wen), 64'd0);
        chk("st_early_valid", 64'(bus1.lsu_resp_valid), 64'd0);
        @(negedge clk);                              // T+3
        #1;
        chk("st_valid", 64'(bus1.lsu_resp_valid), 64'd1);
        check_resp1();
        @(negedge clk);

        // ---- LSU load with response backpressure ----
        d = 64'h1122_3344_5566_7788;
        @(negedge clk);
        bus1.lsu_req_valid = 1'b1; bus1.lsu_wen = 1'b0;
        bus1.lsu_addr = 64'h0000_0000_8000_2000; bus1.lsu_wdt_op = WDT64;
        #1;
        chk("bp_ready", 64'(bus1.lsu_req_ready), 64'd1);
        sb.push_back('{owner: 1'b1, data: d});
        @(negedge clk);
        bus1.lsu_req_valid = 1'b0;
        bus1.lsu_resp_ready = 1'b0;
        bus1.mem_rdata = d;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_resp1();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus1.ifu_req_valid = 1'b1;
            bus1.lsu_req_valid = 1'b1;
            bus1.mem_rdata = ~d;
            #1;
            chk("bp_hold_valid", 64'(bus1.lsu_resp_valid), 64'd1);
            chk("bp_hold_data", bus1.lsu_rdata, d);
            chk("bp_ifu_ready", 64'(bus1.ifu_req_ready), 64'd0);
            chk("bp_lsu_ready", 64'(bus1.lsu_req_ready), 64'd0);
            chk("bp_ifu_resp", 64'(bus1.ifu_resp_valid), 64'd0);
        end
        @(negedge clk);
        bus1.ifu_req_valid = 1'b0;
        bus1.lsu_req_valid = 1'b0;
        bus1.lsu_resp_ready = 1'b1;
        #1;
        chk("bp_release_valid", 64'(bus1.lsu_resp_valid), 64'd1);
        @(negedge clk);
        #1;
        chk("bp_after_valid", 64'(bus1.lsu_resp_valid), 64'd0);
        bus1.lsu_req_valid = 1'b1;
        #1;
        chk("bp_idle_ready", 64'(bus1.lsu_req_ready), 64'd1);
        bus1.lsu_req_valid = 1'b0;                   // withdrawn before the edge
        @(negedge clk);
        #1;
        chk("drop_no_ren", 64'(bus1.mem_ren), 64'd0);
        chk("drop_no_wen", 64'(bus1.mem_wen), 64'd0);

        // ---- Both valid continuously: LSU x4 then IFU, repeating ----
        bus1.ifu_addr = 64'h0000_0000_8000_0100;
        bus1.lsu_addr = 64'h0000_0000_8000_2200;
        bus1.lsu_wen  = 1'b0;
        grants = 0;
        cyc = 0;
        while ((grants < 10 || sb.size() != 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus1.ifu_req_valid = (grants < 10);
            bus1.lsu_req_valid = (grants < 10);
            #1;
            if (bus1.mem_ren) bus1.mem_rdata = model_rd(bus1.mem_addr);
            check_resp1();
            if (bus1.ifu_req_ready || bus1.lsu_req_ready) begin
                exp_lsu = ((grants % 5) != 4);
                chk("order_lsu", 64'(bus1.lsu_req_ready), 64'(exp_lsu));
                chk("order_ifu", 64'(bus1.ifu_req_ready), 64'(!exp_lsu));
                sb.push_back('{owner: exp_lsu,
                               data: model_rd(exp_lsu ? bus1.lsu_addr : bus1.ifu_addr)});
                grants++;
            end
        end
        bus1.ifu_req_valid = 1'b0;
        bus1.lsu_req_valid = 1'b0;
        chk("order_grants", 64'(grants), 64'd10);
        chk("order_sb_empty", 64'(sb.size()), 64'd0);

        // ---- Reset in the middle of WAIT ----
        @(negedge clk);
        @(negedge clk);
        bus1.lsu_req_valid = 1'b1; bus1.lsu_wen = 1'b0;
        bus1.lsu_addr = 64'h0000_0000_8000_3300;
        #1;
        chk("rstw_ready", 64'(bus1.lsu_req_ready), 64'd1);
        @(negedge clk);
        bus1.lsu_req_valid = 1'b0;
        #1;
        chk("rstw_ren", 64'(bus1.mem_ren), 64'd1);
        @(negedge clk);                              // in WAIT
        rst_n = 1'b0;
        bus1.ifu_req_valid = 1'b1;
        #1;
        chk_quiet("rstw");
        @(negedge clk);
        bus1.ifu_req_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("rstw_no_lsu_resp", 64'(bus1.lsu_resp_valid), 64'd0);
            chk("rstw_no_ifu_resp", 64'(bus1.ifu_resp_valid), 64'd0);
        end

        // ---- Three-cycle memory load on dut3 ----
        @(negedge clk);
        bus3.lsu_req_valid = 1'b1; bus3.lsu_wen = 1'b0;
        bus3.lsu_addr = 64'h0000_0000_8000_4000;
        #1;
        chk("lat3_ready", 64'(bus3.lsu_req_ready), 64'd1);
        @(negedge clk);                              // T+1
        bus3.lsu_req_valid = 1'b0;
        #1;
        chk("lat3_ren", 64'(bus3.mem_ren), 64'd1);
        @(negedge clk);                              // T+2
        bus3.mem_rdata = 64'hAAAA_0000_0000_0002;
        #1;
        chk("lat3_ren_once", 64'(bus3.mem_ren), 64'd0);
        chk("lat3_valid_t2", 64'(bus3.lsu_resp_valid), 64'd0);
        @(negedge clk);                              // T+3
        bus3.mem_rdata = 64'hBBBB_0000_0000_0003;
        #1;
        chk("lat3_valid_t3", 64'(bus3.lsu_resp_valid), 64'd0);
        @(negedge clk);                              // T+4
        bus3.mem_rdata = 64'hCCCC_0000_0000_0004;
        #1;
        chk("lat3_valid_t4", 64'(bus3.lsu_resp_valid), 64'd0);
        @(negedge clk);                              // T+5
        bus3.mem_rdata = 64'hDDDD_0000_0000_0005;
        #1;
        chk("lat3_valid_t5", 64'(bus3.lsu_resp_valid), 64'd1);
        chk("lat3_data", bus3.lsu_rdata, 64'hCCCC_0000_0000_0004);
        @(negedge clk);
        #1;
        chk("lat3_done", 64'(bus3.lsu_resp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
